mskaes_32bits_inv_state_core: RTL and testbench
===============================================

# mskaes_32bits_inv_state_core

Masked AES-128 decryption state engine. It processes one column per cycle, using 32 shared bits per cycle toward an external masked inverse S-box and 32 shared bits per cycle from an external inverse key schedule. The block holds the 16-byte shared state, performs InvShiftRows routing, AddRoundKey, and share-wise InvMixColumns, and sequences the 10 rounds with its own controller. It is the decryption counterpart of the encryption core's 32-bit state datapath and sits between the top-level valid/ready data port and the shared inverse S-box.

## Interface
Parameters:
- d, 2, number of shares (d ≥ 2)
- SBOX_LAT, 4, fixed inverse S-box latency in cycles; legal range 3..8

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ciphertext offered
- in_ready  out  1  ciphertext accepted when in_valid & in_ready
- sh_ciphertext  in  128*d  shared ciphertext; byte i at [8*d*i +: 8*d]
- out_valid  out  1  plaintext available
- out_ready  in  1  plaintext consumed when out_valid & out_ready
- sh_plaintext  out  128*d  shared state register, same byte layout
- sbox_in_valid  out  1  sh_4bytes_to_SB carries a live column
- sh_4bytes_to_SB  out  32*d  row j at [8*d*j +: 8*d]
- sh_4bytes_from_SB  in  32*d  S-box result, exactly SBOX_LAT cycles after issue
- key_req  out  1  a key column is consumed this cycle
- key_round  out  4  round-key index requested (10..0)
- key_col  out  2  column index requested
- sh_4bytes_from_key  in  32*d  shared key column, combinationally valid while key_req=1
- busy  out  1  high outside IDLE

Shared encoding follows the codebase's standard: share-interleaved bits. All operations in this block are share-wise linear. No randomness input.

## Operation
- Byte index i = 4*col + row; byte 0 is the first ciphertext byte.
- FSM: IDLE → WHITEN → ROUND → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On handshake, load sh_ciphertext into the state and go to WHITEN.
- WHITEN: 4 cycles, c=0..3.
  - key_req=1, key_round=10, key_col=c.
  - State column c ^= key column.
  - No S-box traffic.
  - Then go to ROUND with rnd=9.
- ROUND: period of SBOX_LAT+4 cycles, local counter t.
  - Issue, t=0..3:
    - sbox_in_valid=1.
    - sh_4bytes_to_SB row j = state byte (row j, column (t−j) mod 4), i.e. InvShiftRows.
  - Writeback, t=SBOX_LAT..SBOX_LAT+3, column c=t−SBOX_LAT:
    - key_req=1, key_round=rnd, key_col=c.
    - new = sh_4bytes_from_SB ^ key.
    - If rnd≠0, apply share-wise InvMixColumns (coefficients 0e,0b,0d,09).
    - Write the result into state column c.
  - All issue reads complete before the first writeback, guaranteed by SBOX_LAT ≥ 3, so no shadow register is needed.
  - After t=SBOX_LAT+3: if rnd=0 go to DONE; else rnd−1, t=0.
- DONE:
  - out_valid=1; sh_plaintext=state, held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in DONE.
- Signals outside their active windows:
  - sh_4bytes_to_SB is forced to 0 when sbox_in_valid=0.
  - key_round and key_col are 0 when key_req=0.
- in_valid while busy is ignored (in_ready=0).

## Timing
- Reset, effective at the next edge:
  - FSM to IDLE; all counters 0.
  - State register cleared to 0, so sh_plaintext=0.
  - in_ready=1; out_valid=0, busy=0, sbox_in_valid=0, key_req=0, sh_4bytes_to_SB=0.
- Reset mid-WHITEN, mid-ROUND, or in DONE aborts the operation. In-flight S-box results returning afterwards are ignored.
- Latency: input handshake at edge 0 → out_valid high from cycle 4 + 10·(SBOX_LAT+4) + 1. For SBOX_LAT=4 that is cycle 85.
- Throughput: one block per latency + 1 (the DONE handshake cycle minimum).
- Output-to-input turnaround: out handshake at edge k, in_ready=1 in cycle k+1.
- Key columns are sampled on the same edge that key_req is high. The key schedule must serve round 10 first, then 9..0, columns 0..3 ascending.

## Test plan
- FIPS-197 vector:
  - Key 000102…0f. The bench key schedule serves inverse round keys. Ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with random sharing, d=2, SBOX_LAT=4.
  - Required: unmasked plaintext 00112233445566778899aabbccddeeff; out_valid first high exactly 85 cycles after the input handshake.
- Share independence: same vector, 100 fresh random sharings, d=3 → identical unmasked result every time.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid and sh_plaintext stable; in_ready=0 throughout; pulse in_valid is ignored.
- Sequencing trace: check key_round/key_col order (10:0..3, 9:0..3, …, 0:0..3), 44 key_req pulses total, and 40 sbox_in_valid pulses, 4 per round in bursts.
- Reset mid-round: assert rst at round 5, t=2 → next cycle in_ready=1, busy=0, sh_plaintext=0; a subsequent FIPS-197 run still decrypts correctly.
- Parameter sweep: SBOX_LAT=3 and 8 with the FIPS vector → correct plaintext; latencies 75 and 125 cycles.

Source files
------------

// File: rtl/mskaes_32bits_inv_state_core.sv
// Masked AES-128 decryption state engine, one column per cycle.
// Holds the shared state and sequences whitening plus ten inverse rounds.
module mskaes_32bits_inv_state_core #(
   parameter int d        = 2,
   parameter int SBOX_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [128*d-1:0]  sh_ciphertext,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [128*d-1:0]  sh_plaintext,
   output logic              sbox_in_valid,
   output logic [32*d-1:0]   sh_4bytes_to_SB,
   input  logic [32*d-1:0]   sh_4bytes_from_SB,
   output logic              key_req,
   output logic [3:0]        key_round,
   output logic [1:0]        key_col,
   input  logic [32*d-1:0]   sh_4bytes_from_key,
   output logic              busy
);

   localparam int BW = 8*d;
   localparam int CW = 32*d;
   localparam logic [3:0] LAT  = 4'(SBOX_LAT);
   localparam logic [3:0] LAST = 4'(SBOX_LAT+3);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WHITEN = 2'd1;
   localparam logic [1:0] S_ROUND  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       fsm;
   logic [3:0]       t;
   logic [3:0]       rnd;
   logic [128*d-1:0] state;

   logic             whiten;
   logic             issue;
   logic             wb;
   logic [1:0]       wb_col;
   logic [CW-1:0]    key_add;
   logic [CW-1:0]    mixed;
   logic [CW-1:0]    wb_data;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // GF(2^8) multiply by a 4-bit constant built from x, x^2, x^3 terms
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] a2;
      logic [7:0] a4;
      logic [7:0] a8;
      a2 = xt(a);
      a4 = xt(a2);
      a8 = xt(a4);
      return (c[0] ? a  : 8'h00) ^ (c[1] ? a2 : 8'h00)
           ^ (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
   endfunction

   assign whiten = (fsm == S_WHITEN);
   assign issue  = (fsm == S_ROUND) && (t < 4'd4);
   assign wb     = (fsm == S_ROUND) && (t >= LAT);
   assign wb_col = 2'(t - LAT);

   assign in_ready      = (fsm == S_IDLE);
   assign out_valid     = (fsm == S_DONE);
   assign busy          = (fsm != S_IDLE);
   assign sbox_in_valid = issue;
   assign sh_plaintext  = state;

   assign key_req   = whiten | wb;
   assign key_round = whiten ? 4'd10 : (wb ? rnd : 4'd0);
   assign key_col   = whiten ? t[1:0] : (wb ? wb_col : 2'd0);

   // InvShiftRows: row j of the issued column t comes from column t-j
   always_comb begin
      logic [1:0] col;
      sh_4bytes_to_SB = '0;
      col = 2'd0;
      if (issue) begin
         for (int j = 0; j < 4; j++) begin
            col = t[1:0] - 2'(j);
            sh_4bytes_to_SB[BW*j +: BW] = state[BW*(4*int'(col) + j) +: BW];
         end
      end
   end

   assign key_add = sh_4bytes_from_SB ^ sh_4bytes_from_key;

   // share-wise InvMixColumns on the interleaved column
   always_comb begin
      logic [7:0] a [4];
      logic [7:0] b [4];
      mixed = '0;
      a = '{default: 8'h00};
      b = '{default: 8'h00};
      for (int s = 0; s < d; s++) begin
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++)
               a[r][k] = key_add[BW*r + d*k + s];
         for (int r = 0; r < 4; r++)
            b[r] = gm(a[r], 4'he) ^ gm(a[(r+1)%4], 4'hb)
                 ^ gm(a[(r+2)%4], 4'hd) ^ gm(a[(r+3)%4], 4'h9);
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++)
               mixed[BW*r + d*k + s] = b[r][k];
      end
   end

   assign wb_data = (rnd != 4'd0) ? mixed : key_add;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm   <= S_IDLE;
         t     <= 4'd0;
         rnd   <= 4'd0;
         state <= '0;
      end else begin
         unique case (fsm)
            S_IDLE: begin
               if (in_valid) begin
                  state <= sh_ciphertext;
                  t     <= 4'd0;
                  fsm   <= S_WHITEN;
               end
            end
            S_WHITEN: begin
               state[CW*t[1:0] +: CW] <= state[CW*t[1:0] +: CW]
                                       ^ sh_4bytes_from_key;
               if (t == 4'd3) begin
                  t   <= 4'd0;
                  rnd <= 4'd9;
                  fsm <= S_ROUND;
               end else begin
                  t <= t + 4'd1;
               end
            end
            S_ROUND: begin
               if (wb)
                  state[CW*wb_col +: CW] <= wb_data;
               if (t == LAST) begin
                  t <= 4'd0;
                  if (rnd == 4'd0)
                     fsm <= S_DONE;
                  else
                     rnd <= rnd - 4'd1;
               end else begin
                  t <= t + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready)
                  fsm <= S_IDLE;
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mskaes_32bits_inv_state_core.sv
// Bench for the masked AES-128 decryption state engine.
// Four configurations with a bench-side masked inverse S-box and key schedule.
module tb_mskaes_32bits_inv_state_core;

   localparam int DMAX = 3;

   typedef logic [43:0][31:0] ks_t;
   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   logic [7:0] sbt  [256];
   logic [7:0] isbt [256];
   vec_t vt [3];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] xt8(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt8(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol(input logic [7:0] v, input int n);
      logic [15:0] w;
      w = {v, v} << n;
      return w[15:8];
   endfunction

   function automatic ks_t expand(input logic [127:0] key);
      ks_t w;
      logic [31:0] tmp;
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]],
                   sbt[tmp[15:8]], sbt[tmp[7:0]]} ^ {rc, 24'h0};
            rc = xt8(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      return w;
   endfunction

   function automatic logic [8*DMAX-1:0] share8r(input logic [7:0] v,
         input logic [8*DMAX-1:0] r, input int dd);
      logic [7:0] acc;
      logic [7:0] sb;
      logic [8*DMAX-1:0] o;
      acc = v;
      o = '0;
      for (int s = 0; s < dd-1; s++) acc = acc ^ r[8*s +: 8];
      for (int s = 0; s < dd; s++) begin
         sb = (s == dd-1) ? acc : r[8*s +: 8];
         for (int b = 0; b < 8; b++) o[b*dd + s] = sb[b];
      end
      return o;
   endfunction

   function automatic logic [7:0] unshare8(input logic [8*DMAX-1:0] w, input int dd);
      logic [7:0] v;
      v = 8'h00;
      for (int b = 0; b < 8; b++)
         for (int s = 0; s < dd; s++) v[b] = v[b] ^ w[b*dd + s];
      return v;
   endfunction

   function automatic logic [128*DMAX-1:0] share128(input logic [127:0] v, input int dd);
      logic [128*DMAX-1:0] o;
      logic [8*DMAX-1:0] sh;
      logic [8*DMAX-1:0] r;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         r = 24'($urandom);
         sh = share8r(v[127-8*i -: 8], r, dd);
         for (int k = 0; k < 8*dd; k++) o[8*dd*i + k] = sh[k];
      end
      return o;
   endfunction

   function automatic logic [127:0] unshare128(input logic [128*DMAX-1:0] w, input int dd);
      logic [127:0] v;
      logic [8*DMAX-1:0] x;
      v = '0;
      for (int i = 0; i < 16; i++) begin
         x = '0;
         for (int k = 0; k < 8*dd; k++) x[k] = w[8*dd*i + k];
         v[127-8*i -: 8] = unshare8(x, dd);
      end
      return v;
   endfunction

   for (genvar k = 0; k < 4; k++) begin : g
      localparam int D = (k == 1) ? 3 : 2;
      localparam int L = (k == 2) ? 3 : ((k == 3) ? 8 : 4);

      logic             rst = 1'b1;
      logic             in_valid = 1'b0;
      logic             in_ready;
      logic [128*D-1:0] ct_sh = '0;
      logic             out_valid;
      logic             out_ready = 1'b0;
      logic [128*D-1:0] pt_sh;
      logic             sbv;
      logic [32*D-1:0]  to_sb;
      logic [32*D-1:0]  from_sb;
      logic             key_req;
      logic [3:0]       key_round;
      logic [1:0]       key_col;
      logic [32*D-1:0]  from_key;
      logic             busy;

      mskaes_32bits_inv_state_core #(.d(D), .SBOX_LAT(L)) dut (
         .clk                (clk),
         .rst                (rst),
         .in_valid           (in_valid),
         .in_ready           (in_ready),
         .sh_ciphertext      (ct_sh),
         .out_valid          (out_valid),
         .out_ready          (out_ready),
         .sh_plaintext       (pt_sh),
         .sbox_in_valid      (sbv),
         .sh_4bytes_to_SB    (to_sb),
         .sh_4bytes_from_SB  (from_sb),
         .key_req            (key_req),
         .key_round          (key_round),
         .key_col            (key_col),
         .sh_4bytes_from_key (from_key),
         .busy               (busy)
      );

      ks_t ks = '0;
      logic [8*DMAX-1:0] sr [4];
      logic [8*DMAX-1:0] kr [4];
      logic [32*D-1:0] sb_next;
      logic [32*D-1:0] pipe [L];

      always @(negedge clk)
         for (int j = 0; j < 4; j++) begin
            sr[j] <= 24'($urandom);
            kr[j] <= 24'($urandom);
         end

      // masked inverse S-box: unmask, look up, reshare with fresh masks
      always_comb begin
         logic [8*DMAX-1:0] x;
         logic [8*DMAX-1:0] y;
         sb_next = '0;
         x = '0;
         y = '0;
         for (int j = 0; j < 4; j++) begin
            x = '0;
            x[8*D-1:0] = to_sb[8*D*j +: 8*D];
            y = share8r(isbt[unshare8(x, D)], sr[j], D);
            sb_next[8*D*j +: 8*D] = y[8*D-1:0];
         end
      end

      always @(posedge clk) begin
         pipe[0] <= sb_next;
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign from_sb = pipe[L-1];

      always_comb begin
         logic [31:0] w;
         logic [8*DMAX-1:0] y;
         from_key = '0;
         w = '0;
         y = '0;
         if (key_req) begin
            w = ks[4*key_round + key_col];
            for (int j = 0; j < 4; j++) begin
               y = share8r(w[31-8*j -: 8], kr[j], D);
               from_key[8*D*j +: 8*D] = y[8*D-1:0];
            end
         end
      end

      int kcnt, scnt, runs, bad, cur, oerr, viol;
      logic mon_clr = 1'b0;

      always @(negedge clk) begin
         if (mon_clr) begin
            kcnt <= 0; scnt <= 0; runs <= 0; bad <= 0;
            cur <= 0; oerr <= 0; viol <= 0;
         end else begin
            if (key_req) begin
               if (key_round != 4'(10 - kcnt/4) || key_col != 2'(kcnt % 4))
                  oerr <= oerr + 1;
               kcnt <= kcnt + 1;
            end else if (key_round != 4'd0 || key_col != 2'd0 || (!sbv && to_sb != '0)) begin
               viol <= viol + 1;
            end
            if (sbv) begin
               scnt <= scnt + 1;
               cur <= cur + 1;
            end else if (cur != 0) begin
               if (cur != 4) bad <= bad + 1;
               runs <= runs + 1;
               cur <= 0;
            end
         end
      end

      task automatic mon_clear();
         mon_clr = 1'b1;
         @(negedge clk); #1;
         mon_clr = 1'b0;
      endtask

      task automatic mon_chk();
         chk($sformatf("c%0d_key_pulses", k), 128'(kcnt), 128'd44);
         chk($sformatf("c%0d_key_order", k), 128'(oerr), 128'd0);
         chk($sformatf("c%0d_sbox_pulses", k), 128'(scnt), 128'd40);
         chk($sformatf("c%0d_sbox_bursts", k), 128'(runs), 128'd10);
         chk($sformatf("c%0d_sbox_burst_len", k), 128'(bad), 128'd0);
         chk($sformatf("c%0d_idle_zero", k), 128'(viol), 128'd0);
      endtask

      task automatic reset_chk();
         rst = 1'b1;
         in_valid = 1'b0;
         out_ready = 1'b0;
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk($sformatf("c%0d_rst_flags", k),
             128'({in_ready, out_valid, busy, sbv, key_req}), 128'(5'b10000));
         chk($sformatf("c%0d_rst_pt", k), 128'(|pt_sh), 128'd0);
         chk($sformatf("c%0d_rst_to_sb", k), 128'(|to_sb), 128'd0);
         rst = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("c%0d_idle_flags", k),
             128'({in_ready, out_valid, busy, sbv, key_req}), 128'(5'b10000));
      endtask

      task automatic run(input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] pt, input int lat, input int hold);
         logic [128*DMAX-1:0] s;
         logic [128*DMAX-1:0] x;
         logic [128*D-1:0] cap;
         int cyc;
         int nbad;
         ks = expand(key);
         s = share128(ct, D);
         ct_sh = s[128*D-1:0];
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         cyc = 1;
         while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk($sformatf("c%0d_latency", k), 128'(cyc), 128'(lat));
         x = '0;
         x[128*D-1:0] = pt_sh;
         chk($sformatf("c%0d_plaintext", k), unshare128(x, D), pt);
         if (hold > 0) begin
            cap = pt_sh;
            nbad = 0;
            for (int i = 0; i < hold; i++) begin
               in_valid = (i == 5 || i == 6);
               s = share128(~ct, D);
               ct_sh = s[128*D-1:0];
               @(posedge clk); #1;
               if (!out_valid || in_ready || !busy || pt_sh !== cap) nbad++;
            end
            in_valid = 1'b0;
            chk($sformatf("c%0d_backpressure", k), 128'(nbad), 128'd0);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk($sformatf("c%0d_turnaround", k),
             128'({in_ready, out_valid, busy}), 128'(3'b100));
      endtask

      task automatic mid_reset(input logic [127:0] key, input logic [127:0] ct);
         logic [128*DMAX-1:0] s;
         int cyc;
         ks = expand(key);
         s = share128(ct, D);
         ct_sh = s[128*D-1:0];
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         cyc = 1;
         // round r starts in cycle 5+(9-r)*(L+4); round 5, t=2
         while (cyc < 5 + 4*(L+4) + 2) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk($sformatf("c%0d_busy_mid", k), 128'(busy), 128'd1);
         rst = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("c%0d_abort_flags", k),
             128'({in_ready, out_valid, busy, sbv, key_req}), 128'(5'b10000));
         chk($sformatf("c%0d_abort_pt", k), 128'(|pt_sh), 128'd0);
         rst = 1'b0;
      endtask
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};
      vt[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};
      vt[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                pt:  128'h6bc1bee22e409f96e93d7e117393172a};

      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         logic [7:0] s;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
         sbt[x] = s;
         isbt[s] = 8'(x);
      end

      g[0].reset_chk();
      g[1].reset_chk();
      g[2].reset_chk();
      g[3].reset_chk();

      g[0].mon_clear();
      g[0].run(vt[0].key, vt[0].ct, vt[0].pt, 85, 0);
      g[0].mon_chk();

      for (int i = 0; i < 3; i++) begin
         g[0].run(vt[i].key, vt[i].ct, vt[i].pt, 85, 0);
         g[2].run(vt[i].key, vt[i].ct, vt[i].pt, 75, 0);
         g[3].run(vt[i].key, vt[i].ct, vt[i].pt, 125, 0);
      end

      g[0].run(vt[0].key, vt[0].ct, vt[0].pt, 85, 20);

      g[0].mid_reset(vt[0].key, vt[0].ct);
      g[0].run(vt[0].key, vt[0].ct, vt[0].pt, 85, 0);

      for (int n = 0; n < 100; n++)
         g[1].run(vt[0].key, vt[0].ct, vt[0].pt, 85, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
